// File: rtl/apb_cmd_pkg.sv
// Shared definitions for the APB command master: FSM state encoding and
// default parameter values.
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int BW_ADDR_DEF        = 32;
  localparam int BW_DATA_DEF        = 32;
  localparam int TIMEOUT_CYCLES_DEF = 256;
  localparam int BW_TIMEOUT_DEF     = 16;

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 requester: turns a valid/ready command into one
// SETUP/ACCESS transfer and returns a buffered response, with ACCESS timeout.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int BW_ADDR        = BW_ADDR_DEF,
  parameter int BW_DATA        = BW_DATA_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int BW_TIMEOUT     = BW_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  // command channel
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [BW_ADDR-1:0] req_addr,
  input  logic [BW_DATA-1:0] req_wdata,
  // response channel
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [BW_DATA-1:0] resp_rdata,
  output logic               resp_err,
  output logic               resp_timeout,
  // APB3 requester
  output logic               spsel,
  output logic               spenable,
  output logic               spwrite,
  output logic [BW_ADDR-1:0] spaddr,
  output logic [BW_DATA-1:0] spwdata,
  input  logic [BW_DATA-1:0] sprdata,
  input  logic               spready,
  input  logic               spslverr
);

  localparam bit                    TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [BW_TIMEOUT-1:0] TO_LIMIT =
    BW_TIMEOUT'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [BW_TIMEOUT-1:0] CNT_MAX  = '1;

  state_e                state, state_nxt;
  logic [BW_TIMEOUT-1:0] to_cnt;
  logic                  to_hit;

  // Abort only while the slave is still stalling; a late spready wins.
  assign to_hit = TO_EN && (to_cnt == TO_LIMIT) && !spready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid)           state_nxt = SETUP;
      SETUP:                            state_nxt = ACCESS;
      ACCESS:  if (spready || to_hit)   state_nxt = RESP;
      RESP:    if (resp_ready)          state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Handshake and bus phase signals decode straight from the state register.
  assign req_ready  = (state == IDLE);
  assign spsel      = (state == SETUP) || (state == ACCESS);
  assign spenable   = (state == ACCESS);
  assign resp_valid = (state == RESP);

  // Command capture doubles as the APB address/control/data drivers, so they
  // stay stable through SETUP and ACCESS and hold their value afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spwrite <= 1'b0;
      spaddr  <= '0;
      spwdata <= '0;
    end else if (state == IDLE && req_valid) begin
      spwrite <= req_write;
      spaddr  <= req_addr;
      spwdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !spready && to_cnt != CNT_MAX) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Response is captured on the ACCESS exit cycle and held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      resp_timeout <= 1'b0;
    end else if (state == ACCESS) begin
      if (spready) begin
        resp_rdata   <= spwrite ? '0 : sprdata;
        resp_err     <= spslverr;
        resp_timeout <= 1'b0;
      end else if (to_hit) begin
        resp_rdata   <= '0;
        resp_err     <= 1'b1;
        resp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a bench-driven register slave and
// TIMEOUT_CYCLES=4.
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err, resp_timeout;
  logic        spsel, spenable, spwrite;
  logic [31:0] spaddr, spwdata, sprdata;
  logic        spready, spslverr;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem [8];

  logic [31:0] rd;
  logic        er, tm;
  int          acc, lat;
  bit          su, st;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .BW_ADDR(32), .BW_DATA(32), .TIMEOUT_CYCLES(4), .BW_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .spsel(spsel), .spenable(spenable), .spwrite(spwrite),
    .spaddr(spaddr), .spwdata(spwdata), .sprdata(sprdata),
    .spready(spready), .spslverr(spslverr)
  );

  // Issues one command (called at a negedge) and plays the slave for it.
  // Returns at the negedge where the response first shows, with latency in
  // cycles after the acceptance edge (-1 if no response appeared).
  task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int waits, input bit stuck, input bit slv_err,
                          output logic [31:0] o_rd, output logic o_er, output logic o_tm,
                          output int o_acc, output int o_lat, output bit o_su, output bit o_st);
    int  n;
    int  idx;
    bit  ready_now;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    o_su  = (spsel === 1'b1) && (spenable === 1'b0) && (spaddr === a) &&
            (spwrite === w) && (!w || spwdata === d);
    o_acc = 0; o_lat = -1; o_st = 1'b1; idx = 0;
    o_rd = 'x; o_er = 1'bx; o_tm = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      idx++;
      if (spsel === 1'b1 && spenable === 1'b1) begin
        o_acc++;
        if (spaddr !== a || spwrite !== w || (w && spwdata !== d)) o_st = 1'b0;
        ready_now = !stuck && (o_acc > waits);
        spready   = ready_now;
        spslverr  = ready_now ? slv_err : 1'b1;
        if (!ready_now)         sprdata = 32'hFFFF_FFFF;
        else if (w || slv_err)  sprdata = 32'hBAD0_0000 | a;
        else                    sprdata = mem[a[4:2]];
        if (ready_now && w && !slv_err) mem[a[4:2]] = d;
      end else begin
        spready = 1'b0; spslverr = 1'b0; sprdata = '0;
        break;
      end
    end
    if (resp_valid === 1'b1) begin
      o_lat = idx;
      o_rd  = resp_rdata;
      o_er  = resp_err;
      o_tm  = resp_timeout;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1; sprdata = '0; spready = 1'b0; spslverr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({req_ready, resp_valid, resp_err, resp_timeout, spsel, spenable, spwrite} !== 7'b1000000)
      $display("FAIL reset_ctrl: got %b want 1000000",
               {req_ready, resp_valid, resp_err, resp_timeout, spsel, spenable, spwrite});
    else passed++;
    total++;
    if ({resp_rdata, spaddr, spwdata} !== 96'd0)
      $display("FAIL reset_data: rdata=%h spaddr=%h spwdata=%h want 0", resp_rdata, spaddr, spwdata);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait();
    logic        w [3]   = '{1'b1, 1'b1, 1'b0};
    logic [31:0] a [3]   = '{32'h0, 32'h4, 32'h4};
    logic [31:0] d [3]   = '{32'd3, 32'd4, 32'h0};
    logic [31:0] exp [3] = '{32'h0, 32'h0, 32'd4};
    for (int k = 0; k < 3; k++) begin
      run_xfer(w[k], a[k], d[k], 0, 1'b0, 1'b0, rd, er, tm, acc, lat, su, st);
      total++;
      if (lat !== 2) $display("FAIL zw_latency[%0d]: got %0d want 2", k, lat); else passed++;
      total++;
      if (acc !== 1) $display("FAIL zw_penable_cycles[%0d]: got %0d want 1", k, acc); else passed++;
      total++;
      if (!su) $display("FAIL zw_setup[%0d]: got bad setup phase want sel=1 en=0 addr=%h", k, a[k]); else passed++;
      total++;
      if ({rd, er, tm} !== {exp[k], 2'b00})
        $display("FAIL zw_resp[%0d]: got rdata=%h err=%b to=%b want rdata=%h err=0 to=0", k, rd, er, tm, exp[k]);
      else passed++;
      @(negedge clk);
      total++;
      if ({resp_valid, req_ready} !== 2'b01)
        $display("FAIL zw_handshake[%0d]: got valid/ready=%b want 01", k, {resp_valid, req_ready});
      else passed++;
    end
  endtask

  task automatic test_wait_states();
    run_xfer(1'b0, 32'h8, 32'h0, 3, 1'b0, 1'b0, rd, er, tm, acc, lat, su, st);
    total++;
    if (acc !== 4) $display("FAIL ws_access_cycles: got %0d want 4", acc); else passed++;
    total++;
    if (!st) $display("FAIL ws_stable: got bus changes during ACCESS want stable addr=%h", 32'h8); else passed++;
    total++;
    if (lat !== 5) $display("FAIL ws_latency: got %0d want 5", lat); else passed++;
    total++;
    if ({rd, er, tm} !== {32'h7, 2'b00})
      $display("FAIL ws_resp: got rdata=%h err=%b to=%b want 7/0/0", rd, er, tm);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_slave_error();
    run_xfer(1'b0, 32'h14, 32'h0, 0, 1'b0, 1'b1, rd, er, tm, acc, lat, su, st);
    total++;
    if ({er, tm} !== 2'b10) $display("FAIL err_flags: got err=%b to=%b want 1/0", er, tm); else passed++;
    total++;
    if (rd !== 32'hBAD0_0014) $display("FAIL err_rdata: got %h want bad00014", rd); else passed++;
    @(negedge clk);
    run_xfer(1'b0, 32'h4, 32'h0, 0, 1'b0, 1'b0, rd, er, tm, acc, lat, su, st);
    total++;
    if ({lat, rd, er, tm} !== {32'd2, 32'd4, 2'b00})
      $display("FAIL err_next_cmd: got lat=%0d rdata=%h err=%b want 2/4/0", lat, rd, er);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 32'h8, 32'h0, 0, 1'b1, 1'b0, rd, er, tm, acc, lat, su, st);
    total++;
    if (acc !== 4) $display("FAIL to_access_cycles: got %0d want 4", acc); else passed++;
    total++;
    if (lat !== 5) $display("FAIL to_latency: got %0d want 5", lat); else passed++;
    total++;
    if ({rd, er, tm} !== {32'h0, 2'b11})
      $display("FAIL to_resp: got rdata=%h err=%b to=%b want 0/1/1", rd, er, tm);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit hold_ok;
    resp_ready = 1'b0;
    run_xfer(1'b0, 32'h8, 32'h0, 0, 1'b0, 1'b0, rd, er, tm, acc, lat, su, st);
    total++;
    if ({lat, rd} !== {32'd2, 32'h7}) $display("FAIL bp_first: got lat=%0d rdata=%h want 2/7", lat, rd); else passed++;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'd9;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h7 || resp_err !== 1'b0 ||
          resp_timeout !== 1'b0 || req_ready !== 1'b0 || spsel !== 1'b0) hold_ok = 1'b0;
    end
    total++;
    if (!hold_ok) $display("FAIL bp_hold: got response/ready/spsel changing want held rdata=7 ready=0 sel=0"); else passed++;
    resp_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({resp_valid, req_ready, spsel} !== 3'b010)
      $display("FAIL bp_after_hs: got valid/ready/sel=%b want 010", {resp_valid, req_ready, spsel});
    else passed++;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if ({spsel, spenable, spwrite, spaddr} !== {3'b101, 32'h4})
      $display("FAIL bp_accept: got sel/en/wr=%b addr=%h want 101/4", {spsel, spenable, spwrite}, spaddr);
    else passed++;
    spready = 1'b1; spslverr = 1'b0; sprdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    spready = 1'b0; sprdata = '0;
    mem[1] = 32'd9;
    total++;
    if ({resp_valid, resp_rdata, resp_err} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL bp_second_resp: got valid=%b rdata=%h err=%b want 1/0/0", resp_valid, resp_rdata, resp_err);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit quiet;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hC; req_wdata = 32'hA5A5_0001;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({spsel, spenable, spwrite, spaddr} !== {3'b111, 32'hC})
      $display("FAIL rm_in_access: got sel/en/wr=%b addr=%h want 111/c", {spsel, spenable, spwrite}, spaddr);
    else passed++;
    spready = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if ({req_ready, resp_valid, resp_err, resp_timeout, spsel, spenable, spwrite} !== 7'b1000000)
      $display("FAIL rm_async_ctrl: got %b want 1000000",
               {req_ready, resp_valid, resp_err, resp_timeout, spsel, spenable, spwrite});
    else passed++;
    total++;
    if ({resp_rdata, spaddr, spwdata} !== 96'd0)
      $display("FAIL rm_async_data: rdata=%h spaddr=%h spwdata=%h want 0", resp_rdata, spaddr, spwdata);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || spsel !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    total++;
    if (!quiet) $display("FAIL rm_no_resp: got activity after reset want idle"); else passed++;
    run_xfer(1'b1, 32'h0, 32'h11, 0, 1'b0, 1'b0, rd, er, tm, acc, lat, su, st);
    total++;
    if ({lat, acc} !== {32'd2, 32'd1} || !su)
      $display("FAIL rm_next_write: got lat=%0d acc=%0d setup_ok=%0d want 2/1/1", lat, acc, su);
    else passed++;
    total++;
    if ({rd, er, tm} !== {32'h0, 2'b00})
      $display("FAIL rm_next_resp: got rdata=%h err=%b to=%b want 0/0/0", rd, er, tm);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    mem[2] = 32'h7;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1);
  end

endmodule
